// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and sizing constants for the 8-bit core.
//   fetch_state_t : fetch FSM states (IDLE, RUN, HALTED)
//   WORD_SIZE     : instruction width in bits
//   INDEX_SIZE    : program counter width
//   NUM_INS       : instruction memory depth (2**INDEX_SIZE)
package cpu_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int INDEX_SIZE = 4;
  localparam int NUM_INS    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register for the fetch stage.
//   clk, rst : clock and synchronous active-high reset
//   load     : replace the PC with target (branch redirect)
//   enable   : advance the PC by one, modulo num_ins
//   target   : redirect address
//   pc       : current PC
//   pc_wrap  : registered one-cycle pulse when an advance wraps num_ins-1 -> 0
module pc_counter #(
  parameter int index_size = cpu_pkg::INDEX_SIZE,
  parameter int num_ins    = cpu_pkg::NUM_INS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  enable,
  input  logic [index_size-1:0] target,
  output logic [index_size-1:0] pc,
  output logic                  pc_wrap
);

  localparam logic [index_size-1:0] LAST_PC = index_size'(num_ins - 1);

  // Load outranks enable; a load to 0 is not a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      pc_wrap <= 1'b0;
    end else if (load) begin
      pc      <= target;
      pc_wrap <= 1'b0;
    end else if (enable) begin
      pc      <= pc + index_size'(1);
      pc_wrap <= (pc == LAST_PC);
    end else begin
      pc_wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register.
//   clk, rst      : clock and synchronous active-high reset
//   prog_count    : address to instruction memory (copy of the PC register)
//   ins_val       : instruction returned combinationally for prog_count
//   stall         : hold PC and IF/ID register
//   branch_taken  : redirect to branch_target and flush the IF/ID register
//   branch_target : redirect address
//   halt          : stop fetching until reset
//   if_ins        : registered instruction for the decoder
//   if_pc         : PC of if_ins
//   if_valid      : if_ins holds a real instruction (0 = bubble)
//   pc_wrap       : one-cycle pulse when a sequential fetch wraps the PC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int word_size  = WORD_SIZE,
  parameter int index_size = INDEX_SIZE,
  parameter int num_ins    = NUM_INS
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [index_size-1:0] prog_count,
  input  logic [word_size-1:0]  ins_val,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [index_size-1:0] branch_target,
  input  logic                  halt,
  output logic [word_size-1:0]  if_ins,
  output logic [index_size-1:0] if_pc,
  output logic                  if_valid,
  output logic                  pc_wrap
);

  fetch_state_t          state;
  logic [index_size-1:0] pc_p0;
  logic [word_size-1:0]  ins_p1;
  logic [index_size-1:0] pc_p1;
  logic                  vld_p1;
  logic                  pc_load;
  logic                  pc_adv;

  // Halt outranks branch, branch outranks stall; only RUN touches the PC.
  assign pc_load = (state == RUN) && !halt && branch_taken;
  assign pc_adv  = (state == RUN) && !halt && !branch_taken && !stall;

  pc_counter #(
    .index_size (index_size),
    .num_ins    (num_ins)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .enable  (pc_adv),
    .target  (branch_target),
    .pc      (pc_p0),
    .pc_wrap (pc_wrap)
  );

  assign prog_count = pc_p0;

  // ---- IF/ID boundary: p0 (PC + memory data) -> p1 (decoder view) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ins_p1 <= '0;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          state  <= halt ? HALTED : RUN;
        end
        RUN: begin
          if (halt) begin
            state  <= HALTED;
            vld_p1 <= 1'b0;
          end else if (branch_taken) begin
            // Flush: the word fetched this cycle is on the wrong path.
            vld_p1 <= 1'b0;
          end else if (!stall) begin
            ins_p1 <= ins_val;
            pc_p1  <= pc_p0;
            vld_p1 <= 1'b1;
          end
        end
        HALTED: begin
          vld_p1 <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign if_ins   = ins_p1;
  assign if_pc    = pc_p1;
  assign if_valid = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] prog_count;
  logic [7:0] ins_val;
  logic       stall;
  logic       branch_taken;
  logic [3:0] branch_target;
  logic       halt;
  logic [7:0] if_ins;
  logic [3:0] if_pc;
  logic       if_valid;
  logic       pc_wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers following the fetch rules.
  int m_pc, m_mode, m_ins, m_ipc, m_valid, m_wrap;  // m_mode: 0 idle, 1 run, 2 halted

  always #5 clk = ~clk;

  // Instruction memory model.
  assign ins_val = {4'hA, prog_count};

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .prog_count    (prog_count),
    .ins_val       (ins_val),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .if_ins        (if_ins),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .pc_wrap       (pc_wrap)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_mode = 0; m_ins = 0; m_ipc = 0; m_valid = 0; m_wrap = 0;
    end else if (m_mode == 0) begin
      m_valid = 0; m_wrap = 0;
      m_mode  = halt ? 2 : 1;
    end else if (m_mode == 1) begin
      m_wrap = 0;
      if (halt) begin
        m_mode = 2; m_valid = 0;
      end else if (branch_taken) begin
        m_pc = int'(branch_target); m_valid = 0;
      end else if (!stall) begin
        m_ins   = 160 + m_pc;        // 8'hA0 + address
        m_ipc   = m_pc;
        m_valid = 1;
        m_wrap  = (m_pc == 15) ? 1 : 0;
        m_pc    = (m_pc + 1) % 16;
      end
    end else begin
      m_valid = 0; m_wrap = 0;
    end
  endtask

  // One clock edge: model follows the sampled inputs, outputs are compared
  // 1 time unit later, and the next inputs are applied on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".prog_count"}, int'(prog_count), m_pc);
    chk({tag, ".if_ins"},     int'(if_ins),     m_ins);
    chk({tag, ".if_pc"},      int'(if_pc),      m_ipc);
    chk({tag, ".if_valid"},   int'(if_valid),   m_valid);
    chk({tag, ".pc_wrap"},    int'(pc_wrap),    m_wrap);
    @(negedge clk);
  endtask

  initial begin
    m_pc = 0; m_mode = 0; m_ins = 0; m_ipc = 0; m_valid = 0; m_wrap = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 4'd0; halt = 1'b0;
    @(negedge clk);

    // Reset and sequence
    step("rst0");
    step("rst1");
    chk("rst_pc", int'(prog_count), 0);
    chk("rst_valid", int'(if_valid), 0);
    chk("rst_ins", int'(if_ins), 0);
    rst = 1'b0;
    step("idle");
    chk("cycle1_pc", int'(prog_count), 0);
    chk("cycle1_valid", int'(if_valid), 0);
    step("f0"); chk("seq_a0", int'(if_ins), 8'hA0); chk("seq_pc0", int'(if_pc), 0); chk("seq_v0", int'(if_valid), 1);
    step("f1"); chk("seq_a1", int'(if_ins), 8'hA1); chk("seq_pc1", int'(if_pc), 1);
    step("f2"); chk("seq_a2", int'(if_ins), 8'hA2); chk("seq_pc2", int'(if_pc), 2);

    // Branch with simultaneous stall at PC=3
    branch_taken = 1'b1; branch_target = 4'd12; stall = 1'b1;
    step("brst");
    chk("brst_pc", int'(prog_count), 12);
    chk("brst_valid", int'(if_valid), 0);
    branch_taken = 1'b0; stall = 1'b0;
    step("brtgt");
    chk("brtgt_ins", int'(if_ins), 8'hAC);
    chk("brtgt_pc", int'(if_pc), 12);
    chk("brtgt_valid", int'(if_valid), 1);

    // Wrap through PC=15
    step("fd");
    step("fe");
    step("ff");
    chk("wrap_ins", int'(if_ins), 8'hAF);
    chk("wrap_pulse", int'(pc_wrap), 1);
    chk("wrap_pc", int'(prog_count), 0);
    step("wrap_after");
    chk("wrap_clear", int'(pc_wrap), 0);
    chk("wrap_a0", int'(if_ins), 8'hA0);

    // Stall at PC=5
    for (int i = 0; i < 4; i++) step("to5");
    chk("pre_stall_ins", int'(if_ins), 8'hA4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall_ins", int'(if_ins), 8'hA4);
      chk("stall_pc", int'(prog_count), 5);
      chk("stall_valid", int'(if_valid), 1);
    end
    stall = 1'b0;
    step("unstall");
    chk("unstall_ins", int'(if_ins), 8'hA5);
    step("f6");

    // Branch to 0 from PC=7 is not a wrap
    chk("pre_br0_pc", int'(prog_count), 7);
    branch_taken = 1'b1; branch_target = 4'd0;
    step("br0");
    chk("br0_wrap", int'(pc_wrap), 0);
    chk("br0_pc", int'(prog_count), 0);
    chk("br0_valid", int'(if_valid), 0);
    branch_taken = 1'b0;
    step("br0_a0");
    chk("br0_ins", int'(if_ins), 8'hA0);

    // Halt at PC=9, branch ignored while halted
    for (int i = 0; i < 8; i++) step("to9");
    chk("pre_halt_pc", int'(prog_count), 9);
    halt = 1'b1;
    step("halt");
    halt = 1'b0; branch_taken = 1'b1; branch_target = 4'd3;
    for (int i = 0; i < 10; i++) begin
      step("halted");
      chk("halted_valid", int'(if_valid), 0);
      chk("halted_pc", int'(prog_count), 9);
      chk("halted_ins", int'(if_ins), 8'hA8);
    end
    branch_taken = 1'b0; rst = 1'b1;
    step("recover_rst");
    chk("recover_pc", int'(prog_count), 0);
    chk("recover_ins", int'(if_ins), 0);
    chk("recover_ifpc", int'(if_pc), 0);
    rst = 1'b0;
    step("recover_idle");
    step("recover_f0");
    chk("recover_a0", int'(if_ins), 8'hA0);

    // Reset together with a branch
    rst = 1'b1; branch_taken = 1'b1; branch_target = 4'd6;
    step("rst_br");
    chk("rst_br_pc", int'(prog_count), 0);
    chk("rst_br_valid", int'(if_valid), 0);
    rst = 1'b0;
    step("rst_br_idle");              // branch still high but IDLE ignores it
    chk("rst_br_idle_pc", int'(prog_count), 0);
    branch_taken = 1'b0;
    step("rst_br_f0");
    chk("rst_br_a0", int'(if_ins), 8'hA0);

    // Halt seen in IDLE
    rst = 1'b1; step("hi_rst");
    rst = 1'b0; halt = 1'b1; step("hi_idle");
    halt = 1'b0; step("hi_h0"); step("hi_h1");
    chk("halt_in_idle_valid", int'(if_valid), 0);
    chk("halt_in_idle_pc", int'(prog_count), 0);

    // Randomized traffic against the model
    rst = 1'b1; step("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      halt          = ($urandom_range(0, 79) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_target = 4'($urandom_range(0, 15));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
